// File: rtl/ram_clr_check_pkg.sv
// Shared definitions for the RAM clear / check family: the common sweep
// state encoding and the address-width-to-depth helper.
package ram_clr_check_pkg;

  // Sweep state encoding shared by the clear controller, the checker and the wrappers.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } mem_state_e;

  // Upper bound on the RAM read latency the compare pipeline supports.
  localparam int RDLAT_MAX = 4;

  // Number of words addressable with an address of the given width.
  function automatic int depth_from_addr(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/ram_rdlat_pipe.sv
// G_RDLAT-stage {valid, addr} delay line. It tracks every issued RAM read so
// that the returning word can be matched with its address. A synchronous
// flush drops all in-flight reads.
module ram_rdlat_pipe
  import ram_clr_check_pkg::*;
#(
  parameter int G_RDLAT = 1,
  parameter int G_ADDR  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              vld_i,
  input  logic [G_ADDR-1:0] addr_i,
  output logic              vld_o,
  output logic [G_ADDR-1:0] addr_o,
  output logic              busy_o
);

  logic [G_RDLAT-1:0]             vld_q;
  logic [G_RDLAT-1:0][G_ADDR-1:0] addr_q;

  if (G_RDLAT == 1) begin : g_single
    // Single stage: capture the read issued this cycle.
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
      // NOTE: the address stages are reset along with the valid bits; the line is a handful of flops, not a RAM array, so this costs nothing.
      if (!rst_n || flush_i) begin
        vld_q  <= '0;
        addr_q <= '0;
      end else begin
        vld_q  <= vld_i;
        addr_q <= addr_i;
      end
    end

    // No stage sits ahead of the tail, so nothing is pending behind it.
    assign busy_o = 1'b0;
  end else begin : g_multi
    // Shift the issued read one stage per clock towards the tail.
    always_ff @(posedge clk) begin
      if (!rst_n || flush_i) begin
        vld_q  <= '0;
        addr_q <= '0;
      end else begin
        vld_q  <= {vld_q[G_RDLAT-2:0], vld_i};
        addr_q <= {addr_q[G_RDLAT-2:0], addr_i};
      end
    end

    // Reads still travelling behind the tail stage.
    assign busy_o = |vld_q[G_RDLAT-2:0];
  end

  assign vld_o  = vld_q[G_RDLAT-1];
  assign addr_o = addr_q[G_RDLAT-1];

endmodule

// File: rtl/ram_clr_check.sv
// Read-side companion to the RAM clear sweep. On chkena it reads every
// address 0..G_DEPTH-1 once and compares each word with G_INIT. It reports a
// sticky fail flag, a saturating mismatch count and the first failing address.
module ram_clr_check
  import ram_clr_check_pkg::*;
#(
  parameter int                G_ADDR  = 8,
  parameter int                G_DEPTH = depth_from_addr(G_ADDR),
  parameter int                G_DATA  = 32,
  parameter int                G_RDLAT = 1,
  parameter logic [G_DATA-1:0] G_INIT  = '0,
  parameter int                G_CNTW  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              chkena,
  output logic              chkrdy,
  output logic              chkre,
  output logic [G_ADDR-1:0] chkaddr,
  input  logic [G_DATA-1:0] rddata,
  output logic              chkfail,
  output logic [G_CNTW-1:0] errcnt,
  output logic [G_ADDR-1:0] erraddr
);

  localparam logic [G_ADDR-1:0] LAST_ADDR = G_ADDR'(G_DEPTH - 1);
  localparam logic [G_CNTW-1:0] CNT_MAX   = '1;

  mem_state_e        state_q,   state_d;
  logic              chkre_q,   chkre_d;
  logic [G_ADDR-1:0] chkaddr_q, chkaddr_d;
  logic              chkfail_q, chkfail_d;
  logic [G_CNTW-1:0] errcnt_q,  errcnt_d;
  logic [G_ADDR-1:0] erraddr_q, erraddr_d;

  logic              tail_vld;
  logic [G_ADDR-1:0] tail_addr;
  logic              pipe_busy;
  logic              mismatch;

  // Tracks each issued read until its data returns. A start flushes it, so
  // reads left over from an aborted sweep never reach the compare.
  ram_rdlat_pipe #(
    .G_RDLAT (G_RDLAT),
    .G_ADDR  (G_ADDR)
  ) u_rdlat_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (chkena),
    .vld_i   (chkre_q),
    .addr_i  (chkaddr_q),
    .vld_o   (tail_vld),
    .addr_o  (tail_addr),
    .busy_o  (pipe_busy)
  );

  // Only the word that belongs to a tracked read is compared.
  assign mismatch = tail_vld && (rddata != G_INIT);

  // Sweep sequencing: address generation, read enable and state.
  // NOTE: every always_comb output gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    chkre_d   = 1'b0;
    chkaddr_d = chkaddr_q;

    unique case (state_q)
      READ: begin
        if (chkaddr_q == LAST_ADDR) begin
          // The last read was issued this cycle; hold the address and let the data return.
          state_d = DRAIN;
        end else begin
          chkre_d   = 1'b1;
          chkaddr_d = chkaddr_q + 1'b1;
        end
      end
      DRAIN: begin
        // Only the tail (or nothing) remains, so its compare happens on this edge.
        if (!pipe_busy) begin
          state_d = DONE;
        end
      end
      default: begin
        // IDLE and DONE wait for a start with all outputs held.
      end
    endcase

    // A start overrides any state, including an unfinished sweep.
    if (chkena) begin
      state_d   = READ;
      chkre_d   = 1'b1;
      chkaddr_d = '0;
    end
  end

  // Result capture: sticky fail, saturating count, first failing address.
  always_comb begin
    chkfail_d = chkfail_q;
    errcnt_d  = errcnt_q;
    erraddr_d = erraddr_q;

    if (mismatch) begin
      chkfail_d = 1'b1;
      if (errcnt_q != CNT_MAX) begin
        errcnt_d = errcnt_q + 1'b1;
      end
      if (!chkfail_q) begin
        erraddr_d = tail_addr;
      end
    end

    // A start discards the previous results together with any compare on this edge.
    if (chkena) begin
      chkfail_d = 1'b0;
      errcnt_d  = '0;
      erraddr_d = '0;
    end
  end

  // State and result registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      chkre_q   <= 1'b0;
      chkaddr_q <= '0;
      chkfail_q <= 1'b0;
      errcnt_q  <= '0;
      erraddr_q <= '0;
    end else begin
      state_q   <= state_d;
      chkre_q   <= chkre_d;
      chkaddr_q <= chkaddr_d;
      chkfail_q <= chkfail_d;
      errcnt_q  <= errcnt_d;
      erraddr_q <= erraddr_d;
    end
  end

  assign chkrdy  = (state_q == IDLE) || (state_q == DONE);
  assign chkre   = chkre_q;
  assign chkaddr = chkaddr_q;
  assign chkfail = chkfail_q;
  assign errcnt  = errcnt_q;
  assign erraddr = erraddr_q;

endmodule

// File: tb/tb_ram_clr_check.sv
// Bench for ram_clr_check. Three instances cover RDLAT=1 (depth 16),
// RDLAT=3 with a 3-bit counter (depth 16) and a single-word sweep. Each
// instance has a behavioural RAM that returns filler data on non-read cycles.
module tb_ram_clr_check;

  localparam int NDUT = 3;

  typedef struct packed {
    logic       fail;
    logic [7:0] cnt;
    logic [3:0] addr;
  } res_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [NDUT-1:0] chkena_v;

  wire [NDUT-1:0]      chkrdy_v;
  wire [NDUT-1:0]      chkre_v;
  wire [NDUT-1:0]      chkfail_v;
  wire [NDUT-1:0][3:0] chkaddr_v;
  wire [NDUT-1:0][7:0] errcnt_v;
  wire [NDUT-1:0][3:0] erraddr_v;

  logic [31:0] mem [NDUT][16];

  logic [3:0] exp_addr_q [$];
  res_t       res_q [$];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < NDUT; k++) begin : g_dut
    localparam int LAT   = (k == 1) ? 3 : 1;
    localparam int DEPTH = (k == 2) ? 1 : 16;
    localparam int CNTW  = (k == 1) ? 3 : 8;

    logic [31:0]     rd_pipe [LAT];
    wire  [31:0]     rddata;
    wire  [CNTW-1:0] ec;

    // Behavioural RAM: data appears LAT clocks after the read, filler otherwise.
    always @(posedge clk) begin
      rd_pipe[0] <= chkre_v[k] ? mem[k][chkaddr_v[k]] : 32'hDEAD_BEEF;
      for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign rddata       = rd_pipe[LAT-1];
    assign errcnt_v[k]  = 8'(ec);

    ram_clr_check #(
      .G_ADDR  (4),
      .G_DEPTH (DEPTH),
      .G_DATA  (32),
      .G_RDLAT (LAT),
      .G_INIT  (32'h0),
      .G_CNTW  (CNTW)
    ) u_dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .chkena  (chkena_v[k]),
      .chkrdy  (chkrdy_v[k]),
      .chkre   (chkre_v[k]),
      .chkaddr (chkaddr_v[k]),
      .rddata  (rddata),
      .chkfail (chkfail_v[k]),
      .errcnt  (ec),
      .erraddr (erraddr_v[k])
    );
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input int k, input string tag);
    check({tag, "_chkrdy"},  32'(chkrdy_v[k]),  32'd1);
    check({tag, "_chkre"},   32'(chkre_v[k]),   32'd0);
    check({tag, "_chkaddr"}, 32'(chkaddr_v[k]), 32'd0);
    check({tag, "_chkfail"}, 32'(chkfail_v[k]), 32'd0);
    check({tag, "_errcnt"},  32'(errcnt_v[k]),  32'd0);
    check({tag, "_erraddr"}, 32'(erraddr_v[k]), 32'd0);
  endtask

  // Expectations for one sweep: every address in order, then the final result.
  task automatic push_expect(input int depth, input logic fail, input int cnt, input int addr);
    for (int a = 0; a < depth; a++) exp_addr_q.push_back(4'(a));
    res_q.push_back('{fail: fail, cnt: 8'(cnt), addr: 4'(addr)});
  endtask

  // Called at the first negedge after the start edge (cycle 1). Pops a
  // read address for every chkre cycle and the result when chkrdy returns.
  task automatic monitor(input int k, input int lat, input string tag);
    int   cyc;
    bit   done;
    res_t r;
    logic [3:0] ea;
    cyc  = 1;
    done = 1'b0;
    while (!done && cyc < 200) begin
      if (chkre_v[k]) begin
        if (exp_addr_q.size() == 0) begin
          check({tag, "_extra_read"}, 32'(chkaddr_v[k]), 32'hFFFF_FFFF);
        end else begin
          ea = exp_addr_q.pop_front();
          check({tag, "_rdaddr"}, 32'(chkaddr_v[k]), 32'(ea));
        end
      end
      if (chkrdy_v[k]) done = 1'b1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    check({tag, "_done_in_budget"}, 32'(done), 32'd1);
    check({tag, "_rdy_latency"}, 32'(cyc), 32'(lat));
    check({tag, "_reads_left"}, 32'(exp_addr_q.size()), 32'd0);
    exp_addr_q.delete();
    if (res_q.size() != 0) begin
      r = res_q.pop_front();
      check({tag, "_chkfail"}, 32'(chkfail_v[k]), 32'(r.fail));
      check({tag, "_errcnt"},  32'(errcnt_v[k]),  32'(r.cnt));
      check({tag, "_erraddr"}, 32'(erraddr_v[k]), 32'(r.addr));
    end
  endtask

  task automatic start(input int k);
    @(negedge clk);
    chkena_v[k] = 1'b1;
    @(negedge clk);
    chkena_v[k] = 1'b0;
  endtask

  task automatic sweep(input int k, input int depth, input logic fail, input int cnt,
                       input int addr, input int lat, input string tag);
    push_expect(depth, fail, cnt, addr);
    start(k);
    monitor(k, lat, tag);
  endtask

  task automatic clear_mem(input int k);
    for (int a = 0; a < 16; a++) mem[k][a] = 32'h0;
  endtask

  initial begin : stim
    bit found;
    rst_n    = 1'b0;
    chkena_v = '0;
    for (int k = 0; k < NDUT; k++) clear_mem(k);

    // Reset state of all instances, and no reads while idle.
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < NDUT; k++) check_reset_values(k, $sformatf("reset%0d", k));
    repeat (3) @(negedge clk);
    check("idle_no_chkre", 32'(chkre_v), 32'd0);

    // Clean RAM, RDLAT=1: 16 reads, ready 18 cycles after the start.
    sweep(0, 16, 1'b0, 0, 0, 18, "clean");

    // Two bad words: first failing address is 5.
    mem[0][5]  = 32'h1;
    mem[0][12] = 32'hFFFF_FFFF;
    sweep(0, 16, 1'b1, 2, 5, 18, "two_err");
    repeat (4) @(negedge clk);
    check("done_hold_rdy", 32'(chkrdy_v[0]),  32'd1);
    check("done_hold_re",  32'(chkre_v[0]),   32'd0);
    check("done_hold_cnt", 32'(errcnt_v[0]),  32'd2);
    check("done_hold_ea",  32'(erraddr_v[0]), 32'd5);

    // RDLAT=3, every word bad, 3-bit counter saturates at 7.
    for (int a = 0; a < 16; a++) mem[1][a] = 32'(a + 1);
    sweep(1, 16, 1'b1, 7, 0, 20, "saturate");

    // Single-word sweep, clean then failing.
    sweep(2, 1, 1'b0, 0, 0, 3, "depth1_clean");
    mem[2][0] = 32'h8000_0000;
    sweep(2, 1, 1'b1, 1, 0, 3, "depth1_err");

    // Restart at chkaddr=9 after a mismatch at 3; words 8 and 9 are still
    // bad and in flight at the restart edge, then everything is cleaned.
    clear_mem(0);
    mem[0][3] = 32'h3;
    mem[0][8] = 32'h8;
    mem[0][9] = 32'h9;
    start(0);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (chkre_v[0] && chkaddr_v[0] == 4'd9) found = 1'b1;
      else @(negedge clk);
    end
    check("restart_reached_9", 32'(found), 32'd1);
    check("restart_pre_fail", 32'(chkfail_v[0]),  32'd1);
    check("restart_pre_ea",   32'(erraddr_v[0]),  32'd3);
    chkena_v[0] = 1'b1;
    @(posedge clk);
    #1;
    chkena_v[0] = 1'b0;
    clear_mem(0);
    push_expect(16, 1'b0, 0, 0);
    @(negedge clk);
    check("restart_addr0",  32'(chkaddr_v[0]), 32'd0);
    check("restart_re",     32'(chkre_v[0]),   32'd1);
    check("restart_fail0",  32'(chkfail_v[0]), 32'd0);
    check("restart_cnt0",   32'(errcnt_v[0]),  32'd0);
    monitor(0, 18, "restart");

    // Reset during DRAIN with a mismatch already recorded.
    mem[0][5]  = 32'h5;
    mem[0][15] = 32'hF;
    start(0);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (!chkre_v[0] && !chkrdy_v[0]) found = 1'b1;
      else @(negedge clk);
    end
    check("drain_reached", 32'(found), 32'd1);
    check("drain_fail",    32'(chkfail_v[0]), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_reset_values(0, "drain_rst");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_rst_no_re", 32'(chkre_v[0]), 32'd0);
    end
    check("post_rst_rdy", 32'(chkrdy_v[0]), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
